pc_transfer_unit: RTL and testbench
===================================

# pc_transfer_unit

Parametrised successor to the processor's cache/loader datapath. It moves a multi-byte program counter between the core and the byte-wide memory port, and holds the ALU cache register. A save channel snapshots the PC and serialises it onto the memory write port under a valid/ready handshake. An independent load channel assembles incoming memory bytes into a full PC and signals completion. It sits between the control unit, the ALU output and the memory interface.

## Interface
Parameters:
- BYTE_W, default 8: width of one memory byte.
- PC_BYTES, default 2: bytes per program counter; legal range is 1 or more. PC width is PC_W = BYTE_W*PC_BYTES.
- CACHE_INIT, default 192: reset value of the cache register.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous abort of both channels.
- alu_out  in  BYTE_W  cache register data.
- cache_write  in  1  load alu_out into the cache register.
- cache_out  out  BYTE_W  cache register contents.
- pc  in  PC_W  current program counter.
- save_start  in  1  request a PC save.
- save_ready  in  1  memory accepts save_out this cycle.
- save_valid  out  1  save_out holds a valid byte.
- save_out  out  BYTE_W  byte being saved.
- save_last  out  1  current save byte is the final one.
- save_busy  out  1  save channel is active.
- mem_out  in  BYTE_W  byte read from memory.
- load_start  in  1  begin assembling a PC.
- load_valid  in  1  mem_out holds a load byte.
- load_out  out  PC_W  last completely assembled PC.
- load_done  out  1  one-cycle pulse: load_out has just been updated.
- load_busy  out  1  load channel is active.

## Operation
Cache register:
- Loads alu_out on any edge where cache_write=1; otherwise holds.
- Independent of both channels and of flush.

Save channel FSM, states S_IDLE and S_SEND:
- S_IDLE with save_start=1:
  - snapshot pc into a PC_W shift register;
  - byte index := PC_BYTES-1;
  - go to S_SEND.
- S_SEND:
  - save_valid=1.
  - save_out = snapshot byte[index], where byte[k] = bits [k*BYTE_W +: BYTE_W]. Bytes go out most-significant first.
  - save_last=1 when index=0.
  - Handshake (save_valid & save_ready): decrement index. If index was 0, return to S_IDLE.
- The snapshot is immune to pc changes after the start edge.
- save_start while in S_SEND is ignored. This includes the cycle of the final handshake. A new save requires a start request while in S_IDLE.
- save_busy=1 exactly in S_SEND.
- save_valid must not drop until its handshake completes, except on flush or reset.

Load channel FSM, states L_IDLE and L_RECV:
- L_IDLE with load_start=1:
  - count := 0;
  - clear the assembly register;
  - go to L_RECV.
- L_RECV with load_valid=1:
  - write mem_out into assembly byte[count]. Bytes arrive least-significant first.
  - count increments.
  - On the byte where count=PC_BYTES-1: write the complete word (this byte merged with the earlier ones) into load_out, pulse load_done for the next cycle, and return to L_IDLE.
- load_valid in L_IDLE is ignored, including in the same cycle as load_start.
- load_start in L_RECV is ignored.
- load_out holds its value between loads. Partial data never appears on load_out.
- load_busy=1 exactly in L_RECV.

Both channels:
- They are fully independent. A simultaneous save_start and load_start both take effect.
- flush=1 forces both FSMs to idle at the next edge and discards the partial assembly. load_out is unchanged, no load_done is issued, and flush beats a simultaneous start request.
- Count and index width is max(1, $clog2(PC_BYTES)). There is no wrap-around, because both counters stop at their terminal value.

## Timing
- Reset values:
  - cache_out = CACHE_INIT;
  - load_out = 0;
  - save_out = 0, and save_out = 0 whenever save_valid=0;
  - save_valid, save_last, save_busy, load_done and load_busy = 0;
  - both FSMs idle.
- Reset asserted mid-transfer aborts the transfer immediately, without waiting for a clock edge.
- Save latency: save_start sampled at edge t gives save_valid=1 and the first byte after edge t. With save_ready held high, the channel emits one byte per cycle, PC_BYTES cycles in total, and save_busy falls after edge t+PC_BYTES.
- Save back-to-back: the earliest next start is sampled at edge t+PC_BYTES+1.
- Load latency: with load_valid held high, load_start sampled at edge t is followed by bytes sampled at edges t+1..t+PC_BYTES. load_out updates at edge t+PC_BYTES, and load_done is high for that one following cycle.
- Gaps in load_valid stall the load channel with no limit.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- PC_BYTES=1: each channel transfers a single byte, and save_last=1 throughout S_SEND.

## Test plan
- Reset check: assert reset asynchronously mid-cycle -> cache_out=0xC0 and load_out=0x0000, with all flags 0, immediately.
- Save with full ready: pc=0xA53C, pulse save_start, save_ready=1, then change pc to 0xFFFF -> save_out is 0xA5 then 0x3C on consecutive cycles, save_last is set only on 0x3C, save_busy is high for 2 cycles.
- Save with backpressure: save_ready=0 for 3 cycles while the first byte is presented -> 0xA5 held stable with save_valid=1, and no byte is skipped or repeated afterward.
- Load: load_start, then 0x34, a 2-cycle load_valid gap, then 0x12 -> load_out=0x1234 with a single load_done pulse; a stray load_valid afterward leaves load_out unchanged.
- Concurrency and flush: start both channels together, then raise flush after one load byte -> both busy flags clear next edge, no load_done, load_out keeps its previous value, cache_write of 0x5A still lands.
- Parameter sweep: PC_BYTES=1 and PC_BYTES=3 with BYTE_W=8 -> with pc=0x123456, the save order is 0x12, 0x34, 0x56, and loading 0x56, 0x34, 0x12 yields 0x123456.

Source files
------------

// File: rtl/pc_transfer_unit.sv
// Program-counter transfer unit: ALU cache register, a serialising PC save channel
// (MSB first, valid/ready) and a PC load channel that assembles bytes LSB first.
module pc_transfer_unit #(
   parameter int BYTE_W     = 8,
   parameter int PC_BYTES   = 2,
   parameter int CACHE_INIT = 192
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   input  logic [BYTE_W-1:0]            alu_out,
   input  logic                         cache_write,
   output logic [BYTE_W-1:0]            cache_out,
   input  logic [BYTE_W*PC_BYTES-1:0]   pc,
   input  logic                         save_start,
   input  logic                         save_ready,
   output logic                         save_valid,
   output logic [BYTE_W-1:0]            save_out,
   output logic                         save_last,
   output logic                         save_busy,
   input  logic [BYTE_W-1:0]            mem_out,
   input  logic                         load_start,
   input  logic                         load_valid,
   output logic [BYTE_W*PC_BYTES-1:0]   load_out,
   output logic                         load_done,
   output logic                         load_busy
);

   localparam int PC_W  = BYTE_W * PC_BYTES;
   localparam int IDX_W = (PC_BYTES > 1) ? $clog2(PC_BYTES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PC_BYTES - 1);

   typedef enum logic {S_IDLE, S_SEND} save_st_t;
   typedef enum logic {L_IDLE, L_RECV} load_st_t;

   save_st_t            save_st_q, save_st_d;
   logic [PC_W-1:0]     shift_q, shift_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                save_valid_q, save_valid_d;
   logic [BYTE_W-1:0]   save_out_q, save_out_d;
   logic                save_last_q, save_last_d;
   logic                save_busy_q, save_busy_d;

   load_st_t            load_st_q, load_st_d;
   logic [IDX_W-1:0]    cnt_q, cnt_d;
   logic [PC_W-1:0]     asm_q, asm_d;
   logic [PC_W-1:0]     load_out_q, load_out_d;
   logic                load_done_q, load_done_d;
   logic                load_busy_q, load_busy_d;

   logic [BYTE_W-1:0]   cache_q, cache_d;

   always_comb begin
      cache_d = cache_write ? alu_out : cache_q;
   end

   // Save channel: the snapshot shifts left so the byte on offer is always the top one.
   always_comb begin
      save_st_d = save_st_q;
      shift_d   = shift_q;
      idx_d     = idx_q;
      if (flush) begin
         save_st_d = S_IDLE;
      end else if (save_st_q == S_IDLE) begin
         if (save_start) begin
            shift_d   = pc;
            idx_d     = LAST_IDX;
            save_st_d = S_SEND;
         end
      end else if (save_ready) begin
         if (idx_q == '0) begin
            save_st_d = S_IDLE;
         end else begin
            idx_d   = idx_q - IDX_W'(1);
            shift_d = shift_q << BYTE_W;
         end
      end
      save_valid_d = (save_st_d == S_SEND);
      save_busy_d  = (save_st_d == S_SEND);
      save_last_d  = (save_st_d == S_SEND) && (idx_d == '0);
      save_out_d   = (save_st_d == S_SEND) ? shift_d[PC_W-1 -: BYTE_W] : '0;
   end

   // Load channel: load_out only ever receives a fully assembled word.
   always_comb begin
      load_st_d   = load_st_q;
      cnt_d       = cnt_q;
      asm_d       = asm_q;
      load_out_d  = load_out_q;
      load_done_d = 1'b0;
      if (flush) begin
         load_st_d = L_IDLE;
         asm_d     = '0;
      end else if (load_st_q == L_IDLE) begin
         if (load_start) begin
            cnt_d     = '0;
            asm_d     = '0;
            load_st_d = L_RECV;
         end
      end else if (load_valid) begin
         for (int k = 0; k < PC_BYTES; k++) begin
            if (cnt_q == IDX_W'(k)) begin
               asm_d[k*BYTE_W +: BYTE_W] = mem_out;
            end
         end
         if (cnt_q == LAST_IDX) begin
            load_out_d  = asm_d;
            load_done_d = 1'b1;
            load_st_d   = L_IDLE;
         end else begin
            cnt_d = cnt_q + IDX_W'(1);
         end
      end
      load_busy_d = (load_st_d == L_RECV);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cache_q      <= BYTE_W'(CACHE_INIT);
         save_st_q    <= S_IDLE;
         shift_q      <= '0;
         idx_q        <= '0;
         save_valid_q <= 1'b0;
         save_out_q   <= '0;
         save_last_q  <= 1'b0;
         save_busy_q  <= 1'b0;
         load_st_q    <= L_IDLE;
         cnt_q        <= '0;
         asm_q        <= '0;
         load_out_q   <= '0;
         load_done_q  <= 1'b0;
         load_busy_q  <= 1'b0;
      end else begin
         cache_q      <= cache_d;
         save_st_q    <= save_st_d;
         shift_q      <= shift_d;
         idx_q        <= idx_d;
         save_valid_q <= save_valid_d;
         save_out_q   <= save_out_d;
         save_last_q  <= save_last_d;
         save_busy_q  <= save_busy_d;
         load_st_q    <= load_st_d;
         cnt_q        <= cnt_d;
         asm_q        <= asm_d;
         load_out_q   <= load_out_d;
         load_done_q  <= load_done_d;
         load_busy_q  <= load_busy_d;
      end
   end

   assign cache_out  = cache_q;
   assign save_valid = save_valid_q;
   assign save_out   = save_out_q;
   assign save_last  = save_last_q;
   assign save_busy  = save_busy_q;
   assign load_out   = load_out_q;
   assign load_done  = load_done_q;
   assign load_busy  = load_busy_q;

endmodule

// File: tb/tb_pc_transfer_unit.sv
// Scoreboard bench for pc_transfer_unit at PC_BYTES = 2 (default), 1 and 3.
module tb_pc_transfer_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, flush, cache_write, mon_en;
   logic [7:0] alu_out;
   int n_chk = 0;
   int n_fail = 0;

   // PC_BYTES = 2
   logic [7:0]  cache2, sout2, mem2;
   logic [15:0] pc2, lout2;
   logic sst2, srdy2, sv2, slast2, sbusy2, lst2, lv2, ldone2, lbusy2;
   // PC_BYTES = 1
   logic [7:0]  cache1, sout1, mem1, pc1, lout1;
   logic sst1, srdy1, sv1, slast1, sbusy1, lst1, lv1, ldone1, lbusy1;
   // PC_BYTES = 3
   logic [7:0]  cache3, sout3, mem3;
   logic [23:0] pc3, lout3;
   logic sst3, srdy3, sv3, slast3, sbusy3, lst3, lv3, ldone3, lbusy3;

   logic [8:0]  q2s[$], q1s[$], q3s[$];
   logic [15:0] q2l[$];
   logic [7:0]  q1l[$];
   logic [23:0] q3l[$];

   pc_transfer_unit dut2 (
      .clk(clk), .reset(reset), .flush(flush), .alu_out(alu_out), .cache_write(cache_write),
      .cache_out(cache2), .pc(pc2), .save_start(sst2), .save_ready(srdy2), .save_valid(sv2),
      .save_out(sout2), .save_last(slast2), .save_busy(sbusy2), .mem_out(mem2),
      .load_start(lst2), .load_valid(lv2), .load_out(lout2), .load_done(ldone2), .load_busy(lbusy2));

   pc_transfer_unit #(.PC_BYTES(1)) dut1 (
      .clk(clk), .reset(reset), .flush(flush), .alu_out(alu_out), .cache_write(cache_write),
      .cache_out(cache1), .pc(pc1), .save_start(sst1), .save_ready(srdy1), .save_valid(sv1),
      .save_out(sout1), .save_last(slast1), .save_busy(sbusy1), .mem_out(mem1),
      .load_start(lst1), .load_valid(lv1), .load_out(lout1), .load_done(ldone1), .load_busy(lbusy1));

   pc_transfer_unit #(.PC_BYTES(3)) dut3 (
      .clk(clk), .reset(reset), .flush(flush), .alu_out(alu_out), .cache_write(cache_write),
      .cache_out(cache3), .pc(pc3), .save_start(sst3), .save_ready(srdy3), .save_valid(sv3),
      .save_out(sout3), .save_last(slast3), .save_busy(sbusy3), .mem_out(mem3),
      .load_start(lst3), .load_valid(lv3), .load_out(lout3), .load_done(ldone3), .load_busy(lbusy3));

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endfunction

   function automatic void extra(input string nm, input logic [31:0] act);
      n_chk++;
      n_fail++;
      $display("FAIL %s: unexpected output %0h with nothing expected", nm, act);
   endfunction

   // Monitors: pop one expectation per save handshake and per load_done pulse.
   always @(negedge clk) begin
      logic [8:0] es;
      if (mon_en) begin
         if (sv2 && srdy2) begin
            if (q2s.size() == 0) extra("save2", {23'd0, slast2, sout2});
            else begin es = q2s.pop_front(); chk("save2_byte", 32'(sout2), 32'(es[7:0])); chk("save2_last", 32'(slast2), 32'(es[8])); end
         end
         if (sv1 && srdy1) begin
            if (q1s.size() == 0) extra("save1", {23'd0, slast1, sout1});
            else begin es = q1s.pop_front(); chk("save1_byte", 32'(sout1), 32'(es[7:0])); chk("save1_last", 32'(slast1), 32'(es[8])); end
         end
         if (sv3 && srdy3) begin
            if (q3s.size() == 0) extra("save3", {23'd0, slast3, sout3});
            else begin es = q3s.pop_front(); chk("save3_byte", 32'(sout3), 32'(es[7:0])); chk("save3_last", 32'(slast3), 32'(es[8])); end
         end
         if (ldone2) begin
            if (q2l.size() == 0) extra("load2", 32'(lout2));
            else chk("load2_word", 32'(lout2), 32'(q2l.pop_front()));
         end
         if (ldone1) begin
            if (q1l.size() == 0) extra("load1", 32'(lout1));
            else chk("load1_word", 32'(lout1), 32'(q1l.pop_front()));
         end
         if (ldone3) begin
            if (q3l.size() == 0) extra("load3", 32'(lout3));
            else chk("load3_word", 32'(lout3), 32'(q3l.pop_front()));
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; cache_write = 1'b0; alu_out = '0; mon_en = 1'b0;
      pc2 = '0; sst2 = 0; srdy2 = 0; mem2 = '0; lst2 = 0; lv2 = 0;
      pc1 = '0; sst1 = 0; srdy1 = 0; mem1 = '0; lst1 = 0; lv1 = 0;
      pc3 = '0; sst3 = 0; srdy3 = 0; mem3 = '0; lst3 = 0; lv3 = 0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_cache2", 32'(cache2), 32'hC0);
      chk("rst_cache3", 32'(cache3), 32'hC0);
      chk("rst_lout2", 32'(lout2), 32'h0);
      chk("rst_flags2", {28'd0, sv2, sbusy2, ldone2, lbusy2}, 32'h0);

      // Dirty the state, then reset asynchronously in the middle of a transfer.
      alu_out = 8'h77; cache_write = 1'b1;
      cyc();
      cache_write = 1'b0;
      chk("cache_write77", 32'(cache2), 32'h77);
      pc2 = 16'h1111; srdy2 = 1'b0; sst2 = 1'b1; lst2 = 1'b1;
      cyc();
      sst2 = 1'b0; lst2 = 1'b0; lv2 = 1'b1; mem2 = 8'hCD;
      cyc();
      mem2 = 8'hAB;
      cyc();
      lv2 = 1'b0;
      chk("pre_rst_lout2", 32'(lout2), 32'hABCD);
      chk("pre_rst_sbusy2", 32'(sbusy2), 32'h1);
      #2 reset = 1'b1;
      #1;
      chk("async_cache2", 32'(cache2), 32'hC0);
      chk("async_lout2", 32'(lout2), 32'h0);
      chk("async_sout2", 32'(sout2), 32'h0);
      chk("async_flags2", {26'd0, sv2, slast2, sbusy2, ldone2, lbusy2, 1'b0}, 32'h0);
      cyc(); cyc();
      reset = 1'b0;
      mon_en = 1'b1;

      // Save with ready held high; pc changes after the start edge.
      pc2 = 16'hA53C; srdy2 = 1'b1; sst2 = 1'b1;
      q2s.push_back({1'b0, 8'hA5}); q2s.push_back({1'b1, 8'h3C});
      cyc();
      sst2 = 1'b0; pc2 = 16'hFFFF;
      chk("sv_busy_c1", 32'(sbusy2), 32'h1);
      cyc();
      chk("sv_busy_c2", 32'(sbusy2), 32'h1);
      cyc();
      chk("sv_busy_end", 32'(sbusy2), 32'h0);
      chk("sv_valid_end", 32'(sv2), 32'h0);
      chk("sv_out_idle", 32'(sout2), 32'h0);

      // Backpressure: first byte held for 3 cycles; start during the final handshake is ignored.
      pc2 = 16'hA53C; srdy2 = 1'b0; sst2 = 1'b1;
      q2s.push_back({1'b0, 8'hA5}); q2s.push_back({1'b1, 8'h3C});
      cyc();
      sst2 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("bp_valid", 32'(sv2), 32'h1);
         chk("bp_byte", 32'(sout2), 32'hA5);
         cyc();
      end
      srdy2 = 1'b1; sst2 = 1'b1;
      cyc();
      cyc();
      sst2 = 1'b0;
      chk("bp_no_restart", 32'(sbusy2), 32'h0);

      // Load with a two-cycle gap, then a stray byte while idle.
      lst2 = 1'b1;
      cyc();
      lst2 = 1'b0; lv2 = 1'b1; mem2 = 8'h34;
      cyc();
      lv2 = 1'b0;
      chk("ld_busy_gap", 32'(lbusy2), 32'h1);
      cyc(); cyc();
      lv2 = 1'b1; mem2 = 8'h12; q2l.push_back(16'h1234);
      cyc();
      lv2 = 1'b0;
      chk("ld_done_pulse", 32'(ldone2), 32'h1);
      cyc();
      chk("ld_done_single", 32'(ldone2), 32'h0);
      lv2 = 1'b1; mem2 = 8'h99;
      cyc();
      lv2 = 1'b0;
      cyc();
      chk("ld_stray_hold", 32'(lout2), 32'h1234);
      chk("ld_stray_busy", 32'(lbusy2), 32'h0);

      // Both channels together, then flush after one load byte.
      pc2 = 16'hBEEF; srdy2 = 1'b0; sst2 = 1'b1; lst2 = 1'b1;
      cyc();
      sst2 = 1'b0; lst2 = 1'b0;
      chk("conc_busy", {30'd0, sbusy2, lbusy2}, 32'h3);
      lv2 = 1'b1; mem2 = 8'h77;
      cyc();
      lv2 = 1'b0; flush = 1'b1; alu_out = 8'h5A; cache_write = 1'b1;
      cyc();
      flush = 1'b0; cache_write = 1'b0;
      chk("flush_busy", {30'd0, sbusy2, lbusy2}, 32'h0);
      chk("flush_sv", {23'd0, sv2, sout2}, 32'h0);
      chk("flush_cache", 32'(cache2), 32'h5A);
      chk("flush_nodone", 32'(ldone2), 32'h0);
      cyc();
      chk("flush_lout", 32'(lout2), 32'h1234);
      flush = 1'b1; sst2 = 1'b1; lst2 = 1'b1;
      cyc();
      flush = 1'b0; sst2 = 1'b0; lst2 = 1'b0;
      chk("flush_beats_start", {30'd0, sbusy2, lbusy2}, 32'h0);
      lst2 = 1'b1;
      cyc();
      lst2 = 1'b0; lv2 = 1'b1; mem2 = 8'h78;
      cyc();
      mem2 = 8'h56; q2l.push_back(16'h5678);
      cyc();
      lv2 = 1'b0;
      cyc();

      // PC_BYTES = 3; a load_valid in the start cycle must be ignored.
      pc3 = 24'h123456; srdy3 = 1'b1; sst3 = 1'b1;
      q3s.push_back({1'b0, 8'h12}); q3s.push_back({1'b0, 8'h34}); q3s.push_back({1'b1, 8'h56});
      cyc();
      sst3 = 1'b0; pc3 = 24'h0;
      cyc(); cyc(); cyc();
      chk("p3_save_busy", 32'(sbusy3), 32'h0);
      lst3 = 1'b1; lv3 = 1'b1; mem3 = 8'hEE;
      cyc();
      lst3 = 1'b0; mem3 = 8'h56;
      cyc();
      mem3 = 8'h34;
      cyc();
      mem3 = 8'h12; q3l.push_back(24'h123456);
      cyc();
      lv3 = 1'b0;
      cyc();

      // PC_BYTES = 1.
      pc1 = 8'hA7; srdy1 = 1'b0; sst1 = 1'b1; q1s.push_back({1'b1, 8'hA7});
      cyc();
      sst1 = 1'b0;
      chk("p1_last", {30'd0, sv1, slast1}, 32'h3);
      srdy1 = 1'b1;
      cyc();
      srdy1 = 1'b0;
      chk("p1_save_busy", 32'(sbusy1), 32'h0);
      lst1 = 1'b1;
      cyc();
      lst1 = 1'b0; lv1 = 1'b1; mem1 = 8'h5C; q1l.push_back(8'h5C);
      cyc();
      lv1 = 1'b0;
      repeat (3) cyc();

      chk("q2s_left", 32'(q2s.size()), 32'h0);
      chk("q2l_left", 32'(q2l.size()), 32'h0);
      chk("q1s_left", 32'(q1s.size()), 32'h0);
      chk("q1l_left", 32'(q1l.size()), 32'h0);
      chk("q3s_left", 32'(q3s.size()), 32'h0);
      chk("q3l_left", 32'(q3l.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
